// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the pipelined MIPS control path.
// Covers opcodes, ALUOp encodings and the per-stage control bundle.
package mips_ctrl_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int ALUOP_W  = 2;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'd9;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic               bne;
        logic               jump;
        logic               link;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic [REG_W-1:0]   dst;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: ID-stage opcode to control bundle.
// Flags unknown opcodes and reports whether the instruction reads rt.
module control_decode
    import mips_ctrl_pkg::*;
(
    input  logic                id_valid_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [REG_W-1:0]    rt_i,
    input  logic [REG_W-1:0]    rd_i,
    output ctrl_bundle_t        bundle_o,
    output logic                uses_rt_o,
    output logic                illegal_o
);

    ctrl_bundle_t dec_s;
    logic         known_s;

    // opcode table; uses_rt depends on opcode alone, bundle is gated by valid
    always_comb begin
        dec_s     = BUBBLE;
        uses_rt_o = 1'b0;
        known_s   = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                dec_s.regwrite = 1'b1;
                dec_s.dst      = rd_i;
                dec_s.aluop    = ALUOP_FUNCT;
                uses_rt_o      = 1'b1;
            end
            OP_ADDIU: begin
                dec_s.regwrite = 1'b1;
                dec_s.alusrc   = 1'b1;
                dec_s.dst      = rt_i;
                dec_s.aluop    = ALUOP_ADD;
            end
            OP_LW: begin
                dec_s.regwrite = 1'b1;
                dec_s.memread  = 1'b1;
                dec_s.memtoreg = 1'b1;
                dec_s.alusrc   = 1'b1;
                dec_s.dst      = rt_i;
            end
            OP_SW: begin
                dec_s.memwrite = 1'b1;
                dec_s.alusrc   = 1'b1;
                uses_rt_o      = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_s.branch = 1'b1;
                dec_s.bne    = (opcode_i == OP_BNE);
                dec_s.aluop  = ALUOP_SUB;
                uses_rt_o    = 1'b1;
            end
            OP_J: begin
                dec_s.jump = 1'b1;
            end
            OP_JAL: begin
                dec_s.jump     = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.link     = 1'b1;
                dec_s.dst      = LINK_REG;
            end
            default: begin
                known_s = 1'b0;
            end
        endcase

        if (id_valid_i && known_s) begin
            bundle_o = dec_s;
        end else begin
            bundle_o = BUBBLE;
        end
        illegal_o = id_valid_i & ~known_s;
    end

endmodule

// File: rtl/control_pipeline_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// plus load-use stall and branch/jump flush generation.
module control_pipeline_unit
    import mips_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                ex_zero,
    output logic                stall,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                flush_ifid,
    output logic                id_jump,
    output logic                ex_alusrc,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic                ex_branch_taken,
    output logic [REG_W-1:0]    ex_dst,
    output logic                mem_memread,
    output logic                mem_memwrite,
    output logic [REG_W-1:0]    mem_dst,
    output logic                mem_regwrite,
    output logic                wb_regwrite,
    output logic                wb_memtoreg,
    output logic                wb_link,
    output logic [REG_W-1:0]    wb_dst,
    output logic                illegal_op
);

    ctrl_bundle_t dec_s;
    ctrl_bundle_t idex_d;
    ctrl_bundle_t idex_q;
    ctrl_bundle_t exmem_q;
    ctrl_bundle_t memwb_q;
    logic         uses_rt_s;
    logic         hazard_s;
    logic         taken_s;

    control_decode u_decode (
        .id_valid_i (id_valid),
        .opcode_i   (id_opcode),
        .rt_i       (id_rt),
        .rd_i       (id_rd),
        .bundle_o   (dec_s),
        .uses_rt_o  (uses_rt_s),
        .illegal_o  (illegal_op)
    );

    assign taken_s  = idex_q.branch & (ex_zero ^ idex_q.bne);
    assign hazard_s = idex_q.memread && (idex_q.dst != {REG_W{1'b0}}) &&
                      ((idex_q.dst == id_rs) || (uses_rt_s && (idex_q.dst == id_rt)));

    // a taken branch squashes the ID instruction, so its hazard is moot
    assign stall           = hazard_s & ~taken_s;
    assign pc_write        = ~stall;
    assign ifid_write      = ~stall;
    assign id_jump         = dec_s.jump & ~taken_s;
    assign flush_ifid      = taken_s | id_jump;
    assign ex_branch_taken = taken_s;

    // ID/EX next state: wrong-path and stalled instructions become bubbles
    always_comb begin
        idex_d = dec_s;
        if (taken_s) begin
            idex_d = BUBBLE;
        end else if (stall) begin
            idex_d = BUBBLE;
        end else begin
            idex_d = dec_s;
        end
    end

    // stage registers; EX/MEM and MEM/WB advance unconditionally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q  <= BUBBLE;
            exmem_q <= BUBBLE;
            memwb_q <= BUBBLE;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= idex_q;
            memwb_q <= exmem_q;
        end
    end

    assign ex_alusrc    = idex_q.alusrc;
    assign ex_aluop     = idex_q.aluop;
    assign ex_dst       = idex_q.dst;
    assign mem_memread  = exmem_q.memread;
    assign mem_memwrite = exmem_q.memwrite;
    assign mem_regwrite = exmem_q.regwrite;
    assign mem_dst      = exmem_q.dst;
    assign wb_regwrite  = memwb_q.regwrite;
    assign wb_memtoreg  = memwb_q.memtoreg;
    assign wb_link      = memwb_q.link;
    assign wb_dst       = memwb_q.dst;

    logic unused_wb_fields_s;
    assign unused_wb_fields_s = ^{memwb_q.memread, memwb_q.memwrite, memwb_q.branch,
                                  memwb_q.bne, memwb_q.jump, memwb_q.alusrc, memwb_q.aluop};

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Randomized scoreboard bench for control_pipeline_unit against an
// instruction-level reference model of the three control stages.
module tb_control_pipeline_unit;

    logic       clk = 1'b0;
    logic       rst_n, id_valid, ex_zero;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall, pc_write, ifid_write, flush_ifid, id_jump;
    logic       ex_alusrc, ex_branch_taken;
    logic [1:0] ex_aluop;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       mem_memread, mem_memwrite, mem_regwrite;
    logic       wb_regwrite, wb_memtoreg, wb_link, illegal_op;

    always #5 clk = ~clk;

    control_pipeline_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
        .flush_ifid(flush_ifid), .id_jump(id_jump), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .ex_branch_taken(ex_branch_taken), .ex_dst(ex_dst),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_dst(mem_dst),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .wb_link(wb_link), .wb_dst(wb_dst),
        .illegal_op(illegal_op)
    );

    // Reference instruction descriptor: what each opcode means, field by field.
    typedef struct packed {
        bit       regwrite, memtoreg, memread, memwrite, branch, bne, jump, link, alusrc;
        bit [1:0] aluop;
        bit [4:0] dst;
    } ictl_t;

    typedef struct {
        logic [6:0]  comb;   // stall pc_write ifid_write flush id_jump taken illegal
        logic [7:0]  ex;     // alusrc aluop dst
        logic [7:0]  mem;    // memread memwrite regwrite dst
        logic [7:0]  wb;     // regwrite memtoreg link dst
    } exp_t;

    exp_t  sb[$];
    ictl_t m_ex, m_mem, m_wb;
    int    n_checks = 0;
    int    n_pass   = 0;

    function automatic bit is_legal(input bit [5:0] op);
        return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9, 6'd35, 6'd43};
    endfunction

    function automatic bit reads_rt(input bit [5:0] op);
        return op inside {6'd0, 6'd4, 6'd5, 6'd43};
    endfunction

    function automatic ictl_t meaning(input bit [5:0] op, input bit [4:0] rt, input bit [4:0] rd);
        ictl_t c = '0;
        case (op)
            6'd0:  begin c.regwrite = 1; c.dst = rd; c.aluop = 2'b10; end
            6'd9:  begin c.regwrite = 1; c.alusrc = 1; c.dst = rt; end
            6'd35: begin c.regwrite = 1; c.memread = 1; c.memtoreg = 1; c.alusrc = 1; c.dst = rt; end
            6'd43: begin c.memwrite = 1; c.alusrc = 1; end
            6'd4:  begin c.branch = 1; c.aluop = 2'b01; end
            6'd5:  begin c.branch = 1; c.bne = 1; c.aluop = 2'b01; end
            6'd2:  begin c.jump = 1; end
            6'd3:  begin c.jump = 1; c.regwrite = 1; c.link = 1; c.dst = 5'd31; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Apply one ID-stage input set, queue the expected outputs for this cycle,
    // then advance the reference pipeline across the next rising edge.
    task automatic issue(input bit rst, input bit vld, input bit [5:0] op,
                         input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                         input bit zero);
        ictl_t in_id;
        bit    taken, hazard, stl, jmp, illegal;
        exp_t  e;
        rst_n = rst; id_valid = vld; id_opcode = op;
        id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = zero;

        in_id   = (vld && is_legal(op)) ? meaning(op, rt, rd) : '0;
        illegal = vld && !is_legal(op);
        taken   = m_ex.branch && (zero != m_ex.bne);
        hazard  = m_ex.memread && (m_ex.dst != 0) &&
                  ((m_ex.dst == rs) || (reads_rt(op) && (m_ex.dst == rt)));
        stl     = hazard && !taken;
        jmp     = in_id.jump && !taken;

        e.comb = {stl, !stl, !stl, taken || jmp, jmp, taken, illegal};
        e.ex   = {m_ex.alusrc, m_ex.aluop, m_ex.dst};
        e.mem  = {m_mem.memread, m_mem.memwrite, m_mem.regwrite, m_mem.dst};
        e.wb   = {m_wb.regwrite, m_wb.memtoreg, m_wb.link, m_wb.dst};
        sb.push_back(e);

        @(posedge clk);
        if (!rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (taken || stl) ? ictl_t'('0) : in_id;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Monitor: every cycle's outputs are compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("comb", {1'b0, stall, pc_write, ifid_write, flush_ifid, id_jump,
                             ex_branch_taken, illegal_op}, {1'b0, e.comb});
                chk("ex",  {ex_alusrc, ex_aluop, ex_dst}, e.ex);
                chk("mem", {mem_memread, mem_memwrite, mem_regwrite, mem_dst}, e.mem);
                chk("wb",  {wb_regwrite, wb_memtoreg, wb_link, wb_dst}, e.wb);
            end
        end
    end

    initial begin
        bit [5:0] ops [8] = '{6'd0, 6'd9, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
        bit [5:0] op;
        bit [4:0] rs, rt, rd;
        int       waited;

        // Unchecked first edge puts the DUT registers into a known state.
        rst_n = 1'b0; id_valid = 1'b1; id_opcode = 6'd35;
        id_rs = 5'd0; id_rt = 5'd8; id_rd = 5'd0; ex_zero = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        @(posedge clk); #1;

        // Reset held with LW in ID, then LW enters EX.
        issue(0, 1, 35, 1, 8, 0, 0);
        issue(0, 1, 35, 1, 8, 0, 0);
        issue(1, 1, 35, 1, 8, 0, 0);
        // Load-use: ADD r9,r8,r10 stalls one cycle and is held in ID.
        issue(1, 1, 0, 8, 10, 9, 0);
        issue(1, 1, 0, 8, 10, 9, 0);
        repeat (3) issue(1, 0, 0, 0, 0, 0, 0);
        // LW r8 then ADDIU r9,r0,5: rt matches nothing relevant, no stall.
        issue(1, 1, 35, 1, 8, 0, 0);
        issue(1, 1, 9, 0, 9, 8, 0);
        issue(1, 1, 35, 1, 8, 0, 0);
        issue(1, 1, 9, 8, 8, 0, 0);
        repeat (3) issue(1, 0, 0, 0, 0, 0, 0);
        // BNE taken (zero=0) and not taken (zero=1).
        issue(1, 1, 5, 1, 2, 0, 0);
        issue(1, 1, 0, 3, 4, 5, 0);
        issue(1, 1, 5, 1, 2, 0, 1);
        issue(1, 1, 0, 3, 4, 5, 1);
        // BEQ taken with a JAL behind it: the JAL is squashed.
        issue(1, 1, 4, 1, 2, 0, 1);
        issue(1, 1, 3, 0, 0, 0, 1);
        // JAL reaching WB with link set and dst 31.
        issue(1, 1, 3, 0, 0, 0, 0);
        repeat (4) issue(1, 0, 0, 0, 0, 0, 0);
        // Unknown opcode, then LW r8 followed by a dependent BEQ and SW.
        issue(1, 1, 63, 1, 2, 3, 0);
        issue(1, 1, 35, 1, 8, 0, 0);
        issue(1, 1, 4, 0, 8, 0, 1);
        issue(1, 1, 4, 0, 8, 0, 1);
        issue(1, 1, 35, 1, 0, 0, 0);
        issue(1, 1, 43, 0, 0, 0, 0);
        // Reset mid-flight discards the pipeline.
        issue(1, 1, 35, 1, 7, 0, 0);
        issue(0, 1, 0, 7, 7, 7, 0);
        issue(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) begin
                rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            end else begin
                rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
            end
            issue($urandom_range(0, 59) != 0, $urandom_range(0, 9) != 0, op, rs, rt, rd,
                  1'($urandom));
        end

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk); #1;
            waited++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_pipeline_unit.md
Name: control_pipeline_unit

Overview:
- Successor to the single-cycle control decoder.
- Decodes the ID-stage opcode into a control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Adds load-use hazard detection, branch/jump flush, BNE and JAL support, and a registered destination-register pipe for the forwarding unit.
- Sits beside the 5-stage datapath; drives PC/IF-ID write enables and all per-stage control.

Parameters:
- OPCODE_W, 6, opcode field width
- REG_W, 5, register-index width
- ALUOP_W, 2, ALU-control selector width
- LINK_REG, 31, destination register for JAL

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  OPCODE_W  opcode of instruction in ID
- id_rs  in  REG_W  rs field in ID
- id_rt  in  REG_W  rt field in ID
- id_rd  in  REG_W  rd field in ID
- ex_zero  in  1  ALU zero flag of instruction in EX
- stall  out  1  load-use stall; PC and IF/ID hold
- pc_write  out  1  equals ~stall
- ifid_write  out  1  equals ~stall
- flush_ifid  out  1  squash IF/ID this cycle
- id_jump  out  1  J/JAL decoded in ID (combinational)
- ex_alusrc  out  1  ALU B-operand select, EX stage
- ex_aluop  out  ALUOP_W  ALU control selector, EX stage
- ex_branch_taken  out  1  branch resolved taken in EX
- ex_dst  out  REG_W  destination register, EX stage
- mem_memread  out  1  memory read, MEM stage
- mem_memwrite  out  1  memory write, MEM stage
- mem_dst  out  REG_W  destination register, MEM stage
- mem_regwrite  out  1  register write, MEM stage
- wb_regwrite  out  1  register write, WB stage
- wb_memtoreg  out  1  write-back select, WB stage
- wb_link  out  1  write PC+4 (JAL), WB stage
- wb_dst  out  REG_W  destination register, WB stage
- illegal_op  out  1  one-cycle pulse for an unknown opcode in ID

Behaviour:
- Reset (rst_n low at posedge): all three pipeline registers load the bubble bundle (all control 0, dst 0). All registered outputs read 0 the cycle after reset. Reset mid-operation discards in-flight instructions.
- Decode is combinational in ID; id_valid=0 forces the bubble bundle.
  - R (0): regwrite, dst=rd, aluop=10.
  - ADDIU (9): regwrite, alusrc, dst=rt, aluop=00.
  - LW (35): regwrite, memread, memtoreg, alusrc, dst=rt.
  - SW (43): memwrite, alusrc, uses_rt.
  - BEQ (4) / BNE (5): branch, bne=(op==5), aluop=01, uses_rt.
  - J (2): jump.
  - JAL (3): jump, regwrite, link, dst=LINK_REG.
  - Any other opcode with id_valid: bubble bundle plus illegal_op=1. No X outputs ever.
- uses_rt=1 for R, SW, BEQ and BNE only.
- stall is combinational from ID/EX contents and ID inputs: ex_memread && ex_dst!=0 && (ex_dst==id_rs || (uses_rt && ex_dst==id_rt)), gated by ~ex_branch_taken.
- ex_branch_taken = ex_branch && (ex_zero XOR ex_bne).
- flush_ifid = ex_branch_taken OR id_jump.
- ID/EX next state, in priority order:
  1. bubble if ex_branch_taken (the instruction in ID is wrong-path);
  2. else bubble if stall;
  3. else the decoded bundle.
- id_jump is gated off when ex_branch_taken.
- EX/MEM and MEM/WB always advance; they never stall.
- Latency: a decoded bundle appears at ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after it is presented in ID.
- A load-use stall lasts exactly 1 cycle: the bubble clears ex_memread.
- Simultaneous taken branch and stall condition: flush wins and stall=0.
- A write to register 0 is never suppressed here; regfile ignores it. The hazard check excludes dst 0.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode constants;
  - ALUOp encodings;
  - the ctrl_bundle struct (regwrite, memtoreg, memread, memwrite, branch, bne, jump, link, alusrc, aluop, dst);
  - the BUBBLE constant.
- One sub-module: control_decode, purely combinational opcode → bundle plus illegal flag.
- The top module holds the three stage registers and the hazard/flush logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with LW in ID → all outputs 0; after release, LW appears at ex_* on the next edge.
- Load-use: LW r8 then ADD r9,r8,r10 → stall=1 for exactly 1 cycle, pc_write=0, EX gets a bubble; ADD reaches EX one cycle later and wb_dst=9 follows.
- Non-hazard: LW r8 then ADDIU r9,r0,5 → stall never asserted; ADDIU has uses_rt=0, so rt=r9 matching is ignored.
- BNE in EX with ex_zero=0 → ex_branch_taken=1, flush_ifid=1, next ex_* is a bubble. With ex_zero=1 → not taken, no flush.
- JAL in ID → id_jump=1 and flush_ifid=1; three cycles later wb_regwrite=1, wb_link=1, wb_dst=31.
- Opcode 63 with id_valid=1 → illegal_op pulses 1 cycle; the EX stage gets a bubble. Taken branch coincident with a load-use condition → stall=0 and flush only.
